// File: rtl/twiddle_sequencer_if.sv
// twiddle_sequencer_if: sample-in, twiddle-ROM and aligned sample/twiddle-out signals of the twiddle sequencer
interface twiddle_sequencer_if #(parameter int WIDTH = 16, parameter int LOG_N = 6);
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             tw_rd;
  logic [LOG_N-1:0] tw_addr;
  logic [WIDTH-1:0] tw_rom_re;
  logic [WIDTH-1:0] tw_rom_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [WIDTH-1:0] do_tw_re;
  logic [WIDTH-1:0] do_tw_im;
  logic             do_bypass;
  logic             do_last;
  modport master (
    output di_en, di_re, di_im, tw_rom_re, tw_rom_im,
    input  tw_rd, tw_addr, do_en, do_re, do_im, do_tw_re, do_tw_im, do_bypass, do_last
  );
  modport slave (
    input  di_en, di_re, di_im, tw_rom_re, tw_rom_im,
    output tw_rd, tw_addr, do_en, do_re, do_im, do_tw_re, do_tw_im, do_bypass, do_last
  );
endinterface

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: counts stage samples, reads twiddle ROM at sel*n*N/M and emits each sample aligned with its twiddle (clock, sync reset, bus: di_* in, tw_* ROM port, do_* out)
module twiddle_sequencer #(
  parameter int WIDTH = 16,
  parameter int LOG_N = 6,
  parameter int LOG_M = 6
) (
  input logic clock,
  input logic reset,
  twiddle_sequencer_if.slave bus
);
  logic [LOG_M-1:0] c;
  logic [LOG_N-1:0] addr;
  logic             s1_en;
  logic [WIDTH-1:0] s1_re;
  logic [WIDTH-1:0] s1_im;
  logic             s1_bypass;
  logic             s1_last;
  if (LOG_M == 2) begin : g_m4
    assign addr = '0;
  end else begin : g_mn
    logic [1:0] sel;
    assign sel  = {c[LOG_M-2], c[LOG_M-1]};
    assign addr = (LOG_N'(sel) * LOG_N'(c[LOG_M-3:0])) << (LOG_N - LOG_M);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      c             <= '0;
      s1_en         <= 1'b0;
      s1_re         <= '0;
      s1_im         <= '0;
      s1_bypass     <= 1'b0;
      s1_last       <= 1'b0;
      bus.tw_rd     <= 1'b0;
      bus.tw_addr   <= '0;
      bus.do_en     <= 1'b0;
      bus.do_re     <= '0;
      bus.do_im     <= '0;
      bus.do_tw_re  <= '0;
      bus.do_tw_im  <= '0;
      bus.do_bypass <= 1'b0;
      bus.do_last   <= 1'b0;
    end else begin
      s1_en     <= bus.di_en;
      bus.tw_rd <= bus.di_en;
      bus.do_en <= s1_en;
      if (bus.di_en) begin
        c           <= c + 1'b1;
        bus.tw_addr <= addr;
        s1_re       <= bus.di_re;
        s1_im       <= bus.di_im;
        s1_bypass   <= addr == '0;
        s1_last     <= c == '1;
      end
      if (s1_en) begin
        bus.do_re     <= s1_re;
        bus.do_im     <= s1_im;
        bus.do_tw_re  <= s1_bypass ? {1'b0, {(WIDTH-1){1'b1}}} : bus.tw_rom_re;
        bus.do_tw_im  <= s1_bypass ? '0 : bus.tw_rom_im;
        bus.do_bypass <= s1_bypass;
        bus.do_last   <= s1_last;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_sequencer.sv
// tb_twiddle_sequencer: scoreboard bench driving three stage sizes (M=64,16,4) of twiddle_sequencer with N=64
module tb_twiddle_sequencer;
  typedef struct {
    int          due;
    logic [15:0] re;
    logic [15:0] im;
    logic [15:0] twr;
    logic [15:0] twi;
    logic        byp;
    logic        last;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset;
  logic        di_en;
  logic [15:0] di_re;
  logic [15:0] di_im;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pend[3];
  always #5 clock = ~clock;
  task automatic chk(int g, string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0h expected %0h", g, nm, a, e);
    end
  endtask
  function automatic logic [15:0] rom_re(logic [5:0] a);
    return 16'(int'(a) * 517 + 11);
  endfunction
  function automatic logic [15:0] rom_im(logic [5:0] a);
    return 16'(~(int'(a) * 263));
  endfunction
  function automatic int ref_addr(int cc, int m);
    int qq = cc / (m / 4);
    int nn = cc % (m / 4);
    int sel = (qq == 1) ? 2 : (qq == 2) ? 1 : qq;
    return sel * nn * (64 / m);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LM = 6 - 2 * g;
    localparam int M = 1 << LM;
    twiddle_sequencer_if #(.WIDTH(16), .LOG_N(6)) bus ();
    twiddle_sequencer #(.WIDTH(16), .LOG_N(6), .LOG_M(LM)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
    );
    assign bus.di_en     = di_en;
    assign bus.di_re     = di_re;
    assign bus.di_im     = di_im;
    assign bus.tw_rom_re = rom_re(bus.tw_addr);
    assign bus.tw_rom_im = rom_im(bus.tw_addr);
    exp_t        q[$];
    exp_t        held = '{default: 0};
    int          cyc = 0;
    int          cnt = 0;
    logic        er = 1'b0;
    logic [5:0]  ea = '0;
    always @(posedge clock) begin
      exp_t e;
      int   a;
      cyc++;
      if (reset) begin
        q.delete();
        cnt  = 0;
        er   = 1'b0;
        ea   = '0;
        held = '{default: 0};
      end else if (di_en) begin
        a      = ref_addr(cnt % M, M);
        e.due  = cyc + 1;
        e.re   = di_re;
        e.im   = di_im;
        e.byp  = (a == 0);
        e.twr  = (a == 0) ? 16'h7fff : rom_re(6'(a));
        e.twi  = (a == 0) ? 16'h0000 : rom_im(6'(a));
        e.last = (cnt % M) == M - 1;
        q.push_back(e);
        cnt++;
        er = 1'b1;
        ea = 6'(a);
      end else begin
        er = 1'b0;
      end
    end
    always @(negedge clock) begin
      exp_t e;
      chk(g, "tw_rd", 32'(bus.tw_rd), 32'(er));
      chk(g, "tw_addr", 32'(bus.tw_addr), 32'(ea));
      if (bus.do_en) begin
        if (q.size() == 0) chk(g, "unexpected_do_en", 32'(bus.do_en), 32'(0));
        else begin
          e = q.pop_front();
          chk(g, "latency_cycle", 32'(cyc), 32'(e.due));
          held = e;
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk(g, "missing_do_en", 32'(bus.do_en), 32'(1));
        void'(q.pop_front());
      end
      chk(g, "do_re", 32'(bus.do_re), 32'(held.re));
      chk(g, "do_im", 32'(bus.do_im), 32'(held.im));
      chk(g, "do_tw_re", 32'(bus.do_tw_re), 32'(held.twr));
      chk(g, "do_tw_im", 32'(bus.do_tw_im), 32'(held.twi));
      chk(g, "do_bypass", 32'(bus.do_bypass), 32'(held.byp));
      chk(g, "do_last", 32'(bus.do_last), 32'(held.last));
      pend[g] = q.size();
    end
  end
  task automatic step(logic r, logic en, logic [15:0] re, logic [15:0] im);
    reset = r;
    di_en = en;
    di_re = re;
    di_im = im;
    @(posedge clock);
    #1;
  endtask
  task automatic rnd(logic r, logic en);
    step(r, en, 16'($urandom), 16'($urandom));
  endtask
  initial begin
    repeat (3) rnd(1'b1, 1'b1);
    repeat (70) rnd(1'b0, 1'b1);
    repeat (2) rnd(1'b0, 1'b0);
    rnd(1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd100, 16'd1100);
    rnd(1'b0, 1'b0);
    rnd(1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd200, 16'd1200);
    step(1'b0, 1'b1, 16'd300, 16'd1300);
    repeat (3) rnd(1'b0, 1'b0);
    repeat (400) rnd(1'b0, 1'($urandom_range(0, 3) != 0));
    rnd(1'b1, 1'b0);
    repeat (30) rnd(1'b0, 1'b1);
    rnd(1'b1, 1'b1);
    repeat (20) rnd(1'b0, 1'b1);
    repeat (6) rnd(1'b0, 1'b0);
    @(negedge clock);
    chk(9, "drain_pending", 32'(pend[0] + pend[1] + pend[2]), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
